// File: rtl/beta_pkg.sv
// Shared types and constants for the beta pipeline.
// Holds the fetch-stage state encoding and the reset instruction.
package beta_pkg;

    typedef enum logic [1:0] {
        IFS_IDLE = 2'd0,
        IFS_REQ  = 2'd1,
        IFS_WAIT = 2'd2
    } ifs_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/beta_ifs_fetch_unit.sv
// Instruction-fetch stage: one outstanding req/gnt/rvalid transaction at a time.
// Redirects that land after a grant drop the wrong-path response and re-fetch.
module beta_ifs_fetch_unit
    import beta_pkg::*;
#(
    parameter int unsigned          DataWidth = 32,
    parameter logic [DataWidth-1:0] BootAddr  = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 ifs_fetch_en_i,
    input  logic                 ifs_redirect_i,
    input  logic [DataWidth-1:0] ifs_redirect_addr_i,
    output logic                 ifs_busy_o,
    output logic                 ifs_valid_o,
    output logic [DataWidth-1:0] ifs_instr_o,
    output logic [DataWidth-1:0] ifs_pc_o,
    output logic                 imem_req_o,
    output logic [DataWidth-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DataWidth-1:0] imem_rdata_i
);

    localparam logic [DataWidth-1:0] PcStep = DataWidth'(32'd4);

    ifs_state_t           state_r, state_s;
    logic [DataWidth-1:0] pc_r, pc_s;
    logic                 discard_r, discard_s;
    logic                 valid_r, valid_s;
    logic [DataWidth-1:0] instr_r, instr_s;
    logic [DataWidth-1:0] pc_out_r, pc_out_s;

    // Next-state, next-PC and response capture.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        discard_s = discard_r;
        valid_s   = 1'b0;
        instr_s   = instr_r;
        pc_out_s  = pc_out_r;

        case (state_r)
            IFS_IDLE: begin
                if (ifs_fetch_en_i) begin
                    state_s = IFS_REQ;
                end else begin
                    state_s = IFS_IDLE;
                end
            end
            IFS_REQ: begin
                if (imem_gnt_i) begin
                    state_s = IFS_WAIT;
                    // A redirect racing the grant makes this response wrong-path.
                    if (ifs_redirect_i) begin
                        discard_s = 1'b1;
                    end else begin
                        discard_s = discard_r;
                    end
                end else begin
                    state_s = IFS_REQ;
                end
            end
            IFS_WAIT: begin
                if (imem_rvalid_i) begin
                    if (discard_r || ifs_redirect_i) begin
                        state_s   = IFS_REQ;
                        discard_s = 1'b0;
                    end else begin
                        state_s  = IFS_IDLE;
                        valid_s  = 1'b1;
                        instr_s  = imem_rdata_i;
                        pc_out_s = pc_r;
                        pc_s     = pc_r + PcStep;
                    end
                end else if (ifs_redirect_i) begin
                    discard_s = 1'b1;
                end else begin
                    state_s = IFS_WAIT;
                end
            end
            default: begin
                state_s   = IFS_IDLE;
                discard_s = 1'b0;
            end
        endcase

        // Redirect target always wins over the sequential PC.
        if (ifs_redirect_i) begin
            pc_s = {ifs_redirect_addr_i[DataWidth-1:2], 2'b00};
        end else begin
            pc_s = pc_s;
        end
    end

    // State, PC and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r   <= IFS_IDLE;
            pc_r      <= {BootAddr[DataWidth-1:2], 2'b00};
            discard_r <= 1'b0;
            valid_r   <= 1'b0;
            instr_r   <= DataWidth'(INSTR_NOP);
            pc_out_r  <= BootAddr;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            discard_r <= discard_s;
            valid_r   <= valid_s;
            instr_r   <= instr_s;
            pc_out_r  <= pc_out_s;
        end
    end

    assign ifs_busy_o  = (state_r != IFS_IDLE);
    assign imem_req_o  = (state_r == IFS_REQ);
    assign imem_addr_o = {pc_r[DataWidth-1:2], 2'b00};
    assign ifs_valid_o = valid_r;
    assign ifs_instr_o = instr_r;
    assign ifs_pc_o    = pc_out_r;

endmodule

// File: tb/tb_beta_ifs_fetch_unit.sv
// Directed bench for the fetch unit; expected values are hand-derived.
module tb_beta_ifs_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        busy;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    int checks;
    int errors;
    int valid_count;

    beta_ifs_fetch_unit #(
        .DataWidth(32),
        .BootAddr (32'h0000_0000)
    ) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .ifs_fetch_en_i     (fetch_en),
        .ifs_redirect_i     (redirect),
        .ifs_redirect_addr_i(redirect_addr),
        .ifs_busy_o         (busy),
        .ifs_valid_o        (valid),
        .ifs_instr_o        (instr),
        .ifs_pc_o           (pc),
        .imem_req_o         (req),
        .imem_addr_o        (addr),
        .imem_gnt_i         (gnt),
        .imem_rvalid_i      (rvalid),
        .imem_rdata_i       (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1ns later and inputs return idle.
    task automatic tick();
        @(posedge clk);
        #1;
        fetch_en = 1'b0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        redirect = 1'b0;
        if (valid) valid_count++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        fetch_en = 1'b0; gnt = 1'b0; rvalid = 1'b0; redirect = 1'b0;
        redirect_addr = 32'h0; rdata = 32'h0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", req); end
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h exp 00000013", instr); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic_fetch();
        fetch_en = 1'b1;
        tick();
        checks++; if (req !== 1'b1 || addr !== 32'h0 || busy !== 1'b1) begin errors++; $display("FAIL basic_req got req=%0b addr=%h busy=%0b exp 1/0/1", req, addr, busy); end
        gnt = 1'b1;
        tick();
        checks++; if (req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_wait got req=%0b busy=%0b exp 0/1", req, busy); end
        rvalid = 1'b1; rdata = 32'h0050_0093;
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", valid); end
        checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got %h exp 00500093", instr); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL basic_pc got %h exp 0", pc); end
        checks++; if (addr !== 32'h4 || busy !== 1'b0) begin errors++; $display("FAIL basic_next got addr=%h busy=%0b exp 4/0", addr, busy); end
    endtask

    task automatic test_back_to_back();
        // fetch_en in the cycle valid is high
        fetch_en = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got %0b exp 0", valid); end
        checks++; if (req !== 1'b1 || addr !== 32'h4) begin errors++; $display("FAIL b2b_req got req=%0b addr=%h exp 1/4", req, addr); end
    endtask

    task automatic test_gnt_delay();
        valid_count = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (req !== 1'b1 || addr !== 32'h4 || busy !== 1'b1) begin errors++; $display("FAIL gnt_hold[%0d] got req=%0b addr=%h busy=%0b exp 1/4/1", i, req, addr, busy); end
        end
        gnt = 1'b1;
        tick();
        rvalid = 1'b1; rdata = 32'h1111_1111;
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'h4 || instr !== 32'h1111_1111) begin errors++; $display("FAIL gnt_resp got v=%0b pc=%h instr=%h exp 1/4/11111111", valid, pc, instr); end
        tick(); tick();
        checks++; if (valid_count !== 1) begin errors++; $display("FAIL gnt_pulses got %0d exp 1", valid_count); end
    endtask

    task automatic test_redirect_wait();
        valid_count = 0;
        fetch_en = 1'b1;
        tick();
        gnt = 1'b1;
        tick();
        redirect = 1'b1; redirect_addr = 32'h8000_0102;
        tick();
        checks++; if (req !== 1'b0 || addr !== 32'h8000_0100) begin errors++; $display("FAIL redir_wait got req=%0b addr=%h exp 0/80000100", req, addr); end
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h8000_0100) begin errors++; $display("FAIL redir_drop got v=%0b req=%0b addr=%h exp 0/1/80000100", valid, req, addr); end
        gnt = 1'b1;
        tick();
        rvalid = 1'b1; rdata = 32'h2222_2222;
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'h8000_0100 || instr !== 32'h2222_2222) begin errors++; $display("FAIL redir_resp got v=%0b pc=%h instr=%h exp 1/80000100/22222222", valid, pc, instr); end
        checks++; if (valid_count !== 1) begin errors++; $display("FAIL redir_pulses got %0d exp 1", valid_count); end
    endtask

    task automatic test_redirect_same_cycle();
        fetch_en = 1'b1;
        tick();
        gnt = 1'b1;
        tick();
        redirect = 1'b1; redirect_addr = 32'h0000_1003; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        tick();
        checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h0000_1000) begin errors++; $display("FAIL same_drop got v=%0b req=%0b addr=%h exp 0/1/00001000", valid, req, addr); end
        gnt = 1'b1;
        tick();
        rvalid = 1'b1; rdata = 32'h4444_4444;
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'h0000_1000 || instr !== 32'h4444_4444) begin errors++; $display("FAIL same_resp got v=%0b pc=%h instr=%h exp 1/00001000/44444444", valid, pc, instr); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC; fetch_en = 1'b1;
        tick();
        checks++; if (req !== 1'b1 || addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got req=%0b addr=%h exp 1/fffffffc", req, addr); end
        gnt = 1'b1;
        tick();
        rvalid = 1'b1; rdata = 32'h3333_3333;
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_resp got v=%0b pc=%h exp 1/fffffffc", valid, pc); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", addr); end
    endtask

    task automatic test_reset_mid();
        fetch_en = 1'b1;
        tick();
        gnt = 1'b1;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || req !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctl got busy=%0b req=%0b v=%0b exp 0/0/0", busy, req, valid); end
        checks++; if (instr !== 32'h0000_0013 || pc !== 32'h0 || addr !== 32'h0) begin errors++; $display("FAIL rstmid_data got instr=%h pc=%h addr=%h exp 00000013/0/0", instr, pc, addr); end
        @(negedge clk);
        rstn = 1'b1;
        rvalid = 1'b1; rdata = 32'h5555_5555;
        tick();
        checks++; if (valid !== 1'b0 || busy !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL rstmid_late got v=%0b busy=%0b req=%0b exp 0/0/0", valid, busy, req); end
        tick();
        checks++; if (req !== 1'b0 || instr !== 32'h0000_0013) begin errors++; $display("FAIL rstmid_idle got req=%0b instr=%h exp 0/00000013", req, instr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        valid_count = 0;
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_gnt_delay();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beta_ifs_fetch_unit.md
# beta_ifs_fetch_unit

Instruction-fetch stage responding to the pipeline control unit. It accepts the fetch-enable pulse, runs a req/gnt/rvalid transaction on the instruction memory port, reports busy back to the control unit, and presents each fetched instruction with its PC to the if-to-dec pipe. It also absorbs control-hazard and trap redirects, discarding in-flight responses from the wrong path.

## Interface
- DataWidth, 32: width of PC, address and instruction lines.
- BootAddr, 32'h0000_0000: PC value after reset.
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- ifs_fetch_en_i  in  1  fetch request from the control unit; sampled only in IDLE.
- ifs_redirect_i  in  1  control-hazard or trap redirect; one-cycle pulse.
- ifs_redirect_addr_i  in  DataWidth  redirect target.
- ifs_busy_o  out  1  high while a transaction is in REQ or WAIT.
- ifs_valid_o  out  1  one-cycle pulse: ifs_instr_o and ifs_pc_o are new.
- ifs_instr_o  out  DataWidth  fetched instruction, held until the next valid.
- ifs_pc_o  out  DataWidth  address of ifs_instr_o.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  DataWidth  request address; word aligned.
- imem_gnt_i  in  1  request accepted.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  DataWidth  read data.

## Operation
- State machine with three states:
  - IDLE: no request outstanding.
  - REQ: imem_req_o high, waiting for grant.
  - WAIT: granted, waiting for rvalid.
- pc_q is the next fetch address.
- imem_addr_o = {pc_q[DataWidth-1:2], 2'b00}. pc_q low bits are always forced to 0 when loaded.
- IDLE transitions:
  - fetch_en=1 → REQ.
  - Otherwise stay in IDLE.
  - rvalid is ignored in IDLE.
- REQ transitions:
  - gnt=1 → WAIT.
  - Otherwise stay in REQ, holding req and addr stable.
- WAIT transitions:
  - rvalid=1 and discard_q=0: capture rdata→instr, pc_q→pc, pulse valid, pc_q += 4 (modulo 2^DataWidth, wraps), go to IDLE.
  - rvalid=1 and discard_q=1: drop the data, clear discard_q, go to REQ (re-fetch at the redirected pc_q).
- Redirect in any state: pc_q ← {redirect_addr[DataWidth-1:2], 2'b00}.
  - IDLE: stay IDLE; if fetch_en is also high, go to REQ at the new address.
  - REQ without gnt: the address changes next cycle and req stays high (legal; not yet granted).
  - REQ with gnt in the same cycle: go to WAIT and set discard_q=1.
  - WAIT: set discard_q=1. If rvalid arrives in the same cycle, drop it and go directly to REQ.
- ifs_busy_o = (state != IDLE). It is combinational from state.
- Only one outstanding transaction; req never asserted in WAIT.

## Timing
- Reset values: state=IDLE, pc_q=BootAddr, imem_req_o=0, ifs_busy_o=0, ifs_valid_o=0, ifs_instr_o=INSTR_NOP, ifs_pc_o=BootAddr, discard_q=0.
- Reset is asserted asynchronously. Deassertion takes effect at the next clock edge.
- Reset mid-transaction abandons the transaction. A late rvalid after reset is ignored (state is IDLE).
- Minimum fetch latency: fetch_en sampled at edge 0 → req high in cycle 1. gnt in cycle 1 → WAIT in cycle 2. rvalid in cycle 2 → valid_o high in cycle 3. That is 3 cycles from fetch_en to valid.
- ifs_valid_o is registered and high for exactly one cycle per accepted response.
- Back-to-back: fetch_en is sampled again in the cycle valid_o is high (state IDLE).
- Redirect adds one full memory round trip when it hits a granted transaction.

## Structure
- beta_pkg additions:
  - typedef enum logic[1:0] {IFS_IDLE, IFS_REQ, IFS_WAIT} ifs_state_t.
  - localparam INSTR_NOP = 32'h0000_0013.
- Single module, no sub-modules. PC register and FSM are kept in one always_ff with the asynchronous reset; next-state logic goes in always_comb.

## Test plan
- Reset then fetch_en at cycle 0, gnt immediately, rvalid at cycle 2 with 0x00500093 → valid_o pulse at cycle 3, instr=0x00500093, pc=0x0, next imem_addr=0x4.
- Grant delayed 3 cycles → req and addr held constant for those cycles, busy=1 throughout, one valid pulse only.
- Redirect to 0x80000102 while in WAIT, rvalid 2 cycles later → no valid pulse. New req at addr 0x80000100. Its response gives valid with pc=0x80000100.
- Redirect and rvalid in the same cycle → data dropped, next cycle req at the redirect address.
- pc_q=0xFFFFFFFC fetch completes → pc_q wraps to 0x0.
- rstn_i low during WAIT, rvalid after release → outputs at reset values, no valid pulse, req low until the next fetch_en.
